result_history_display: RTL and testbench

Downstream display stage for the 4-bit decode-and-execute datapath. It captures the combinational 4-bit result `rd` on a debounced-edge strobe into a 4-deep history (newest at right) and time-multiplexes the four stored values onto a common-anode 4-digit seven-segment display as hex digits. It replaces the single static digit driver on the board top level; the ALU feeds `rd_in`, and the board drives `seg`/`an`.

---
 rtl/result_history_display.sv | 141 ++++++++++++++
 tb/tb_result_history_display.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_history_display.sv
// ---------------------------------------------------------------------------
// result_history_display
//
// Captures the 4-bit execute-stage result on each debounced rising edge of a
// push-button into a 4-deep history (newest entry on the rightmost digit) and
// time-multiplexes the four stored values onto a common-anode 4-digit
// seven-segment display as hex digits.
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   rd_in    in   [3:0] result to record, sampled only on the capture edge
//   capture  in   asynchronous push-button level, rising edge records rd_in
//   clear    in   synchronous active-high history clear
//   seg      out  [6:0] segments {a,b,c,d,e,f,g}, active-low
//   an       out  [3:0] digit anodes, active-low one-hot, an[0] rightmost
//   count    out  [2:0] number of valid history entries (0..4)
//
// Optional feature (macro BLANK_EMPTY_EN):
//   defined   -> digits without a valid entry are dark (seg = 7'b1111111)
//   undefined -> empty digits show "0"
// ---------------------------------------------------------------------------
module result_history_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rd_in,
    input  logic       capture,
    input  logic       clear,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [2:0] count
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    // Capture synchronizer and edge detect
    logic s1, s2, prev;
    logic cap_pulse;

    // History: h[0] newest, h[3] oldest
    logic [3:0][3:0] h;
    logic [2:0]      cnt;
`ifdef BLANK_EMPTY_EN
    logic [3:0]      v;
`endif

    // Scanner
    logic [DIV_W-1:0] div;
    logic [1:0]       dig;

    function automatic logic [6:0] hex7(input logic [3:0] x);
        logic [6:0] s;
        case (x)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b1110010;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Synchronizer flops are deliberately untouched by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= capture;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign cap_pulse = s2 & ~prev;

    // Clear wins over a coincident pulse; that pulse is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h   <= '0;
            cnt <= 3'd0;
`ifdef BLANK_EMPTY_EN
            v   <= 4'b0000;
`endif
        end else if (clear) begin
            h   <= '0;
            cnt <= 3'd0;
`ifdef BLANK_EMPTY_EN
            v   <= 4'b0000;
`endif
        end else if (cap_pulse) begin
            h <= {h[2], h[1], h[0], rd_in};
            if (cnt != 3'd4) begin
                cnt <= cnt + 3'd1;
            end
`ifdef BLANK_EMPTY_EN
            v <= {v[2:0], 1'b1};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            dig <= 2'd0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            dig <= dig + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign an    = ~(4'b0001 << dig);
    assign count = cnt;

`ifdef BLANK_EMPTY_EN
    assign seg = v[dig] ? hex7(h[dig]) : 7'b1111111;
`else
    assign seg = hex7(h[dig]);
`endif

endmodule

// File: tb/tb_result_history_display.sv
module tb_result_history_display;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rd_in = 4'h0;
    logic       capture = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] count;

    int checks = 0;
    int failures = 0;

    result_history_display #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .rd_in(rd_in), .capture(capture),
        .clear(clear), .seg(seg), .an(an), .count(count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [16];
    logic [3:0] hist [$];      // hist[0] newest
    int         cyc;           // edges since reset release
    logic       c1, c2, c3;    // capture sampled 1, 2, 3 edges ago

    function automatic int m_dig();
        return (cyc / RD) % 4;
    endfunction

    function automatic logic [6:0] m_seg();
        int d = m_dig();
        if (d < hist.size()) return seg_tab[hist[d]];
`ifdef BLANK_EMPTY_EN
        return 7'b1111111;
`else
        return seg_tab[0];
`endif
    endfunction

    task automatic model_reset();
        hist.delete();
        cyc = 0;
        c1 = 0; c2 = 0; c3 = 0;
    endtask

    // A rising edge of the sampled capture level is recorded two edges later.
    task automatic model_edge();
        logic pulse;
        pulse = c2 & ~c3;
        if (clear) begin
            hist.delete();
        end else if (pulse) begin
            hist.push_front(rd_in);
            if (hist.size() > 4) void'(hist.pop_back());
        end
        c3 = c2; c2 = c1; c1 = capture;
        cyc++;
    endtask

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("an",    {3'b0, an},    {3'b0, ~(4'b0001 << m_dig())});
        cmp("seg",   seg,           m_seg());
        cmp("count", {4'b0, count}, 7'(hist.size()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [3:0] val, input int hi, input int lo);
        rd_in = val;
        capture = 1'b1;
        ticks(hi);
        capture = 1'b0;
        ticks(lo);
    endtask

    task automatic wait_dig(input int d, input string name);
        int n = 0;
        while (m_dig() != d && n < 20) begin
            tick();
            n++;
        end
        if (m_dig() != d) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout waiting for digit %0d", name, d);
        end
    endtask

    typedef struct {
        logic [3:0] val;
        logic [6:0] exp_seg;
    } vec_t;

    vec_t vecs [16];

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};
        for (int i = 0; i < 16; i++) begin
            vecs[i].val = 4'(i);
            vecs[i].exp_seg = seg_tab[i];
        end
        model_reset();

        // Reset values
        #12;
        cmp("rst_an", {3'b0, an}, {3'b0, 4'b1110});
`ifdef BLANK_EMPTY_EN
        cmp("rst_seg", seg, 7'b1111111);
`else
        cmp("rst_seg", seg, 7'b0000001);
`endif
        cmp("rst_count", {4'b0, count}, 7'd0);
        rst_n = 1'b1;

        // Idle scanning
        ticks(20);

        // 0xA held high for 3 cycles -> exactly one capture
        press(4'hA, 3, 6);
        cmp("single_cap_count", {4'b0, count}, 7'd1);
        wait_dig(0, "cap_a");
        cmp("cap_a_seg", seg, 7'b0001000);

        // 1..5 -> 5,4,3,2 right to left
        for (int i = 1; i <= 5; i++) press(4'(i), 1, 3);
        cmp("full_count", {4'b0, count}, 7'd4);
        for (int d = 0; d < 4; d++) begin
            wait_dig(d, "hist_scan");
            cmp("hist_digit", seg, seg_tab[5 - d]);
        end

        // Table: each hex value captured then shown on the rightmost digit
        for (int i = 0; i < 16; i++) begin
            press(vecs[i].val, 1, 2);
            wait_dig(0, "tab");
            cmp("tab_seg", seg, vecs[i].exp_seg);
        end

        // Clear coinciding with a pulse, 3 entries stored
        clear = 1'b1; tick(); clear = 1'b0; tick();
        for (int i = 1; i <= 3; i++) press(4'(i + 6), 1, 3);
        cmp("pre_clear_count", {4'b0, count}, 7'd3);
        capture = 1'b1; rd_in = 4'hF;
        ticks(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cmp("clear_count", {4'b0, count}, 7'd0);
        ticks(3);
        capture = 1'b0;
        ticks(2);
        cmp("clear_no_defer", {4'b0, count}, 7'd0);
        wait_dig(0, "clear_scan");
`ifdef BLANK_EMPTY_EN
        cmp("clear_seg", seg, 7'b1111111);
`else
        cmp("clear_seg", seg, 7'b0000001);
`endif

        // Reset mid-scan at digit 2 with a capture inside the synchronizer
        press(4'h3, 1, 3);
        wait_dig(2, "rst_mid");
        capture = 1'b1; rd_in = 4'h9;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst_an", {3'b0, an}, {3'b0, 4'b1110});
        cmp("async_rst_count", {4'b0, count}, 7'd0);
        model_reset();
        capture = 1'b0;
        #3;
        rst_n = 1'b1;
        ticks(8);
        cmp("no_spurious", {4'b0, count}, 7'd0);

`ifdef BLANK_EMPTY_EN
        press(4'h7, 1, 3);
        for (int d = 0; d < 4; d++) begin
            wait_dig(d, "blank");
            cmp("blank_seg", seg, (d == 0) ? 7'b0001111 : 7'b1111111);
        end
`endif

        // Randomized capture / clear traffic
        for (int i = 0; i < 400; i++) begin
            rd_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) capture = ~capture;
            clear = ($urandom_range(0, 40) == 0);
            tick();
        end
        clear = 1'b0;
        capture = 1'b0;
        ticks(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
